// File: rtl/mem_access_stage_pkg.sv
// mem_access_stage_pkg: shared widths, timeout limit and MEM-stage FSM state codes
package mem_access_stage_pkg;
  localparam int PKG_DSIZE = 16;
  localparam int PKG_ASIZE = 5;
  localparam int PKG_ISIZE = 16;
  localparam int PKG_MADDR = 8;
  localparam int TIMEOUT   = 15;
  typedef enum logic {MEM_IDLE = 1'b0, MEM_ACCESS = 1'b1} mem_state_t;
endpackage

// File: rtl/mem_access_stage_mem_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline register (clk, rst, bubble; w_addr/wb_data/wen in -> registered outs), bubble inserts a zeroed no-op
module mem_wb_reg #(
  parameter int DSIZE = 16,
  parameter int ASIZE = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bubble,
  input  logic [ASIZE-1:0] w_addr,
  input  logic [DSIZE-1:0] wb_data,
  input  logic             wen,
  output logic [ASIZE-1:0] w_addr_out,
  output logic [DSIZE-1:0] wb_data_out,
  output logic             wen_out
);
  always_ff @(posedge clk) begin
    w_addr_out  <= (rst || bubble) ? '0 : w_addr;
    wb_data_out <= (rst || bubble) ? '0 : wb_data;
    wen_out     <= (rst || bubble) ? 1'b0 : wen;
  end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage with req/ack data-memory handshake, upstream stall, write-back mux and MEM/WB register; ports: EXE/MEM inputs, dmem_* bus, stall_out, MEM/WB outputs, mem_err_out; MEM_TIMEOUT_EN enables the access timeout
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int DSIZE = PKG_DSIZE,
  parameter int ASIZE = PKG_ASIZE,
  parameter int ISIZE = PKG_ISIZE,
  parameter int MADDR = PKG_MADDR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ASIZE-1:0] w_addr_in,
  input  logic [DSIZE-1:0] w_data_in,
  input  logic [DSIZE-1:0] Rdata2_in,
  input  logic             memWrite_in,
  input  logic             memRead_in,
  input  logic             memToReg_in,
  input  logic             wen_in,
  input  logic             jal_in,
  input  logic [ISIZE-1:0] PC_in,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [MADDR-1:0] dmem_addr,
  output logic [DSIZE-1:0] dmem_wdata,
  input  logic             dmem_ack,
  input  logic [DSIZE-1:0] dmem_rdata,
  output logic             stall_out,
  output logic [ASIZE-1:0] w_addr_out,
  output logic [DSIZE-1:0] wb_data_out,
  output logic             wen_out,
  output logic             mem_err_out
);
  mem_state_t state;
  logic mem_op, tmo, bubble;
  logic [DSIZE-1:0] wb_data;
  assign mem_op = memRead_in | memWrite_in;
`ifdef MEM_TIMEOUT_EN
  logic [3:0] cnt;
  logic err;
  always_ff @(posedge clk) begin
    cnt <= (rst || state == MEM_IDLE) ? 4'd0 : cnt + {3'd0, ~dmem_ack};
    err <= rst ? 1'b0 : err | tmo;
  end
  // an ack arriving on the final cycle completes normally instead of timing out
  assign tmo = (state == MEM_ACCESS) & ~dmem_ack & (cnt == 4'(TIMEOUT - 1));
  assign mem_err_out = err;
`else
  assign tmo = 1'b0;
  assign mem_err_out = 1'b0;
`endif
  assign stall_out = ~rst & (((state == MEM_IDLE) & mem_op) | ((state == MEM_ACCESS) & ~dmem_ack & ~tmo));
  // a timed-out access retires as a bubble so the dropped load/store never writes back
  assign bubble = stall_out | tmo;
  assign wb_data = jal_in ? DSIZE'(PC_in) : memToReg_in ? dmem_rdata : w_data_in;
  always_ff @(posedge clk)
    if (rst) begin
      state      <= MEM_IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
    end else if (state == MEM_IDLE) begin
      if (mem_op) begin
        state      <= MEM_ACCESS;
        dmem_req   <= 1'b1;
        dmem_we    <= memWrite_in;
        dmem_addr  <= w_data_in[MADDR-1:0];
        dmem_wdata <= Rdata2_in;
      end
    end else if (dmem_ack || tmo) begin
      state    <= MEM_IDLE;
      dmem_req <= 1'b0;
    end
  mem_wb_reg #(.DSIZE(DSIZE), .ASIZE(ASIZE)) u_mem_wb (
    .clk(clk),
    .rst(rst),
    .bubble(bubble),
    .w_addr(w_addr_in),
    .wb_data(wb_data),
    .wen(wen_in),
    .w_addr_out(w_addr_out),
    .wb_data_out(wb_data_out),
    .wen_out(wen_out)
  );
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed table vectors for single-cycle ops plus hand sequences for load, store, reset and timeout
module tb_mem_access_stage;
  logic clk = 1'b0;
  logic rst;
  logic [4:0] w_addr_in;
  logic [15:0] w_data_in, Rdata2_in, PC_in, dmem_rdata;
  logic memWrite_in, memRead_in, memToReg_in, wen_in, jal_in, dmem_ack;
  logic dmem_req, dmem_we, stall_out, wen_out, mem_err_out;
  logic [7:0] dmem_addr;
  logic [15:0] dmem_wdata, wb_data_out;
  logic [4:0] w_addr_out;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk(clk), .rst(rst), .w_addr_in(w_addr_in), .w_data_in(w_data_in), .Rdata2_in(Rdata2_in),
    .memWrite_in(memWrite_in), .memRead_in(memRead_in), .memToReg_in(memToReg_in), .wen_in(wen_in),
    .jal_in(jal_in), .PC_in(PC_in), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall_out(stall_out),
    .w_addr_out(w_addr_out), .wb_data_out(wb_data_out), .wen_out(wen_out), .mem_err_out(mem_err_out)
  );

  typedef struct {
    logic [4:0]  w_addr;
    logic [15:0] w_data;
    logic        mem_to_reg;
    logic        wen;
    logic        jal;
    logic [15:0] pc;
    logic [15:0] rdata;
    logic [15:0] exp_wb;
    logic        exp_wen;
    logic [4:0]  exp_waddr;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    w_addr_in = '0; w_data_in = '0; Rdata2_in = '0; PC_in = '0; dmem_rdata = '0;
    memWrite_in = 0; memRead_in = 0; memToReg_in = 0; wen_in = 0; jal_in = 0; dmem_ack = 0;
  endtask

  task automatic chk_wb(input string name, input logic [15:0] d, input logic w, input logic [4:0] a);
    chk({name, "_wb_data"}, 32'(wb_data_out), 32'(d));
    chk({name, "_wen"}, 32'(wen_out), 32'(w));
    chk({name, "_waddr"}, 32'(w_addr_out), 32'(a));
  endtask

  initial begin
    vecs[0] = '{5'd3,  16'h1234, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h1234, 1'b1, 5'd3};
    vecs[1] = '{5'd31, 16'h5555, 1'b0, 1'b1, 1'b1, 16'h0041, 16'h0000, 16'h0041, 1'b1, 5'd31};
    vecs[2] = '{5'd7,  16'hFFFF, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'hFFFF, 1'b0, 5'd7};
    vecs[3] = '{5'd12, 16'h7777, 1'b1, 1'b1, 1'b1, 16'h00FF, 16'hDEAD, 16'h00FF, 1'b1, 5'd12};
    vecs[4] = '{5'd1,  16'hA5A5, 1'b0, 1'b1, 1'b0, 16'h0000, 16'hDEAD, 16'hA5A5, 1'b1, 5'd1};

    idle_inputs();
    rst = 1;
    memRead_in = 1;
    #1;
    chk("rst_stall", 32'(stall_out), 0);
    tick();
    tick();
    chk("rst_req", 32'(dmem_req), 0);
    chk("rst_err", 32'(mem_err_out), 0);
    chk_wb("rst", 16'h0, 1'b0, 5'd0);
    memRead_in = 0;
    rst = 0;
    tick();

    for (int i = 0; i < 5; i++) begin
      w_addr_in = vecs[i].w_addr; w_data_in = vecs[i].w_data; memToReg_in = vecs[i].mem_to_reg;
      wen_in = vecs[i].wen; jal_in = vecs[i].jal; PC_in = vecs[i].pc; dmem_rdata = vecs[i].rdata;
      dmem_ack = (i == 4);
      #1;
      chk($sformatf("vec%0d_stall", i), 32'(stall_out), 0);
      tick();
      chk_wb($sformatf("vec%0d", i), vecs[i].exp_wb, vecs[i].exp_wen, vecs[i].exp_waddr);
      chk($sformatf("vec%0d_req", i), 32'(dmem_req), 0);
    end
    idle_inputs();

    // load, ack in the first ACCESS cycle
    memRead_in = 1; memToReg_in = 1; wen_in = 1; w_addr_in = 5'd5; w_data_in = 16'h0010;
    #1;
    chk("ld_stall_idle", 32'(stall_out), 1);
    tick();
    chk("ld_req", 32'(dmem_req), 1);
    chk("ld_we", 32'(dmem_we), 0);
    chk("ld_addr", 32'(dmem_addr), 32'h10);
    chk_wb("ld_bubble", 16'h0, 1'b0, 5'd0);
    dmem_ack = 1; dmem_rdata = 16'hBEEF;
    #1;
    chk("ld_stall_ack", 32'(stall_out), 0);
    tick();
    chk_wb("ld_done", 16'hBEEF, 1'b1, 5'd5);
    chk("ld_req_drop", 32'(dmem_req), 0);
    idle_inputs();
    tick();

    // store, ack on the third ACCESS cycle
    memWrite_in = 1; memRead_in = 1; Rdata2_in = 16'h00AA; w_data_in = 16'h0020; w_addr_in = 5'd9; wen_in = 0;
    #1;
    chk("st_stall0", 32'(stall_out), 1);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("st_req%0d", c), 32'(dmem_req), 1);
      chk($sformatf("st_we%0d", c), 32'(dmem_we), 1);
      chk($sformatf("st_addr%0d", c), 32'(dmem_addr), 32'h20);
      chk($sformatf("st_wdata%0d", c), 32'(dmem_wdata), 32'h00AA);
      chk_wb($sformatf("st_bubble%0d", c), 16'h0, 1'b0, 5'd0);
      dmem_ack = (c == 2);
      #1;
      chk($sformatf("st_stall%0d", c + 1), 32'(stall_out), (c == 2) ? 0 : 1);
    end
    tick();
    chk_wb("st_done", 16'h0020, 1'b0, 5'd9);
    chk("st_req_drop", 32'(dmem_req), 0);
    idle_inputs();

    // ack while IDLE is ignored
    dmem_ack = 1;
    #1;
    chk("idle_ack_stall", 32'(stall_out), 0);
    tick();
    chk("idle_ack_req", 32'(dmem_req), 0);
    idle_inputs();

    // reset mid-ACCESS, late ack afterwards
    memRead_in = 1; memToReg_in = 1; wen_in = 1; w_addr_in = 5'd4; w_data_in = 16'h0033;
    tick();
    chk("rm_req", 32'(dmem_req), 1);
    idle_inputs();
    rst = 1;
    #1;
    chk("rm_stall_rst", 32'(stall_out), 0);
    tick();
    chk("rm_req_rst", 32'(dmem_req), 0);
    chk("rm_addr_rst", 32'(dmem_addr), 0);
    chk_wb("rm_rst", 16'h0, 1'b0, 5'd0);
    rst = 0;
    dmem_ack = 1; dmem_rdata = 16'h9999;
    #1;
    chk("rm_late_ack_stall", 32'(stall_out), 0);
    tick();
    chk("rm_late_ack_req", 32'(dmem_req), 0);
    chk_wb("rm_late_ack", 16'h0, 1'b0, 5'd0);
    idle_inputs();
    memRead_in = 1;
    #1;
    chk("rm_reidle_stall", 32'(stall_out), 1);
    tick();
    chk("rm_reidle_req", 32'(dmem_req), 1);
    dmem_ack = 1;
    tick();
    idle_inputs();
    tick();

`ifdef MEM_TIMEOUT_EN
    memRead_in = 1; memToReg_in = 1; wen_in = 1; w_addr_in = 5'd6; w_data_in = 16'h0044;
    tick();
    for (int c = 1; c <= 15; c++) begin
      #1;
      chk($sformatf("to_stall%0d", c), 32'(stall_out), (c == 15) ? 0 : 1);
      chk($sformatf("to_req%0d", c), 32'(dmem_req), 1);
      tick();
    end
    chk("to_req_drop", 32'(dmem_req), 0);
    chk("to_err", 32'(mem_err_out), 1);
    chk_wb("to_bubble", 16'h0, 1'b0, 5'd0);
    idle_inputs();
    w_data_in = 16'h1234; wen_in = 1; w_addr_in = 5'd3;
    #1;
    chk("to_next_stall", 32'(stall_out), 0);
    tick();
    chk_wb("to_next", 16'h1234, 1'b1, 5'd3);
    chk("to_err_sticky", 32'(mem_err_out), 1);
`else
    chk("no_timeout_err", 32'(mem_err_out), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
